// File: rtl/seg7_reader.sv
// rtl/seg7_reader.sv - 7-segment bus reader: settle filter, hex decode, digit FIFO
module seg7_reader #(
    parameter int STABLE_CYCLES  = 4,
    parameter int FIFO_DEPTH     = 4,
    parameter int ACTIVE_LOW_SEG = 0
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [6:0]                         segments_in,
    input  logic                               digit_ready,
    output logic [3:0]                         digit_out,
    output logic                               digit_valid,
    output logic                               invalid,
    output logic                               blank,
    output logic                               overflow,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count
);

    localparam int              CW       = $clog2(FIFO_DEPTH + 1);
    localparam int              PW       = $clog2(FIFO_DEPTH);
    localparam logic [7:0]      CNT_LAST = 8'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0]   CNT_FULL = CW'(FIFO_DEPTH);

    // Input stage and stability tracker state
    logic [6:0]     r_s1;
    logic [6:0]     r_prev;
    logic [7:0]     r_cnt;
    logic           r_committed;

    // FIFO state
    logic [3:0]     r_mem [FIFO_DEPTH];
    logic [PW-1:0]  r_wr_ptr;
    logic [PW-1:0]  r_rd_ptr;
    logic [CW-1:0]  r_count;

    // Status flags
    logic           r_invalid;
    logic           r_blank;
    logic           r_overflow;

    logic [6:0]     w_seg_fixed;
    logic           w_commit;
    logic           w_hex;
    logic [3:0]     w_digit;
    logic           w_is_blank;
    logic           w_push;
    logic           w_pop;
    logic           w_full;
    logic           w_wr_en;

    assign w_seg_fixed = (ACTIVE_LOW_SEG != 0) ? ~segments_in : segments_in;

    // The pattern in s1 has matched prev for the full window and is not yet committed
    assign w_commit   = (r_s1 == r_prev) && !r_committed && (r_cnt == CNT_LAST);
    assign w_is_blank = (r_s1 == 7'h00);

    assign digit_valid = (r_count != '0);
    assign w_full      = (r_count == CNT_FULL);
    assign w_pop       = digit_valid & digit_ready;
    assign w_push      = w_commit & w_hex;
    // A push into a full FIFO only lands if a pop frees the head slot in the same cycle
    assign w_wr_en     = w_push & (!w_full | w_pop);

    assign digit_out   = digit_valid ? r_mem[r_rd_ptr] : 4'd0;
    assign fifo_count  = r_count;
    assign invalid     = r_invalid;
    assign blank       = r_blank;
    assign overflow    = r_overflow;

    // Decode the candidate pattern (gfedcba) to a hex digit
    always_comb begin
        w_hex   = 1'b1;
        w_digit = 4'd0;
        case (r_s1)
            7'h3F: w_digit = 4'h0;
            7'h06: w_digit = 4'h1;
            7'h5B: w_digit = 4'h2;
            7'h4F: w_digit = 4'h3;
            7'h66: w_digit = 4'h4;
            7'h6D: w_digit = 4'h5;
            7'h7D: w_digit = 4'h6;
            7'h07: w_digit = 4'h7;
            7'h7F: w_digit = 4'h8;
            7'h6F: w_digit = 4'h9;
            7'h77: w_digit = 4'hA;
            7'h7C: w_digit = 4'hB;
            7'h39: w_digit = 4'hC;
            7'h5E: w_digit = 4'hD;
            7'h79: w_digit = 4'hE;
            7'h71: w_digit = 4'hF;
            default: w_hex = 1'b0;
        endcase
    end

    // Register the polarity-corrected segment bus
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1 <= 7'h00;
        end else begin
            r_s1 <= w_seg_fixed;
        end
    end

    // Track how long s1 has been unchanged; committed starts set so the
    // all-off pattern seen out of reset is never reported
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev      <= 7'h00;
            r_cnt       <= 8'd0;
            r_committed <= 1'b1;
        end else if (r_s1 != r_prev) begin
            r_prev      <= r_s1;
            r_cnt       <= 8'd0;
            r_committed <= 1'b0;
        end else if (!r_committed && (r_cnt == CNT_LAST)) begin
            r_committed <= 1'b1;
        end else if (!r_committed) begin
            r_cnt       <= r_cnt + 8'd1;
        end
    end

    // FIFO storage and write pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= 4'd0;
            end
            r_wr_ptr <= '0;
        end else if (w_wr_en) begin
            r_mem[r_wr_ptr] <= w_digit;
            r_wr_ptr        <= r_wr_ptr + 1'b1;
        end
    end

    // FIFO read pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr <= '0;
        end else if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // FIFO occupancy; simultaneous push and pop leaves it unchanged
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else begin
            case ({w_wr_en, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Commit-time flags: invalid pulse, blank level, sticky overflow
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_invalid  <= 1'b0;
            r_blank    <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            r_invalid <= w_commit & !w_hex & !w_is_blank;
            if (w_commit) begin
                r_blank <= w_is_blank;
            end
            if (w_push && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg7_reader.sv
// tb/tb_seg7_reader.sv - randomized bench for seg7_reader against a run-length reference model
module tb_seg7_reader;

    localparam int S = 4;
    localparam int D = 4;
    localparam int RUN_SAT = 1000;
    localparam logic [6:0] GLYPH [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                          7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] seg = 7'h00;
    logic       rdy = 1'b0;
    logic [3:0] dout;
    logic       dv;
    logic       inv;
    logic       blk;
    logic       ovf;
    logic [2:0] cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: run length of identical samples, digit queue, flags
    logic [6:0] m_last;
    int         m_run;
    int         m_q[$];
    bit         m_inv;
    bit         m_blank;
    bit         m_ovf;

    always #5 clk = ~clk;

    seg7_reader #(.STABLE_CYCLES(S), .FIFO_DEPTH(D), .ACTIVE_LOW_SEG(0)) dut (
        .clk         (clk),
        .rst         (rst),
        .segments_in (seg),
        .digit_ready (rdy),
        .digit_out   (dout),
        .digit_valid (dv),
        .invalid     (inv),
        .blank       (blk),
        .overflow    (ovf),
        .fifo_count  (cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int decode(input logic [6:0] p);
        for (int i = 0; i < 16; i++) begin
            if (GLYPH[i] == p) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_last  = 7'h00;
        m_run   = RUN_SAT;
        m_q.delete();
        m_inv   = 1'b0;
        m_blank = 1'b1;
        m_ovf   = 1'b0;
    endtask

    // A value sampled S+1 times in a row is reported on the following edge
    task automatic model_step(input logic [6:0] s, input logic r);
        int d;
        bit do_pop;
        do_pop = (m_q.size() > 0) && r;
        m_inv  = 1'b0;
        if (do_pop) void'(m_q.pop_front());
        if (m_run == S + 1) begin
            d = decode(m_last);
            if (d >= 0) begin
                m_blank = 1'b0;
                if (m_q.size() < D) m_q.push_back(d);
                else m_ovf = 1'b1;
            end else if (m_last == 7'h00) begin
                m_blank = 1'b1;
            end else begin
                m_inv   = 1'b1;
                m_blank = 1'b0;
            end
        end
        if (s == m_last) begin
            if (m_run < RUN_SAT) m_run++;
        end else begin
            m_last = s;
            m_run  = 1;
        end
    endtask

    task automatic check_all();
        check("digit_valid", dv, m_q.size() > 0);
        check("digit_out", dout, (m_q.size() > 0) ? m_q[0] : 0);
        check("fifo_count", cnt, m_q.size());
        check("invalid", inv, m_inv);
        check("blank", blk, m_blank);
        check("overflow", ovf, m_ovf);
    endtask

    task automatic cycle(input logic [6:0] s, input logic r);
        seg = s;
        rdy = r;
        @(posedge clk);
        model_step(s, r);
        #1;
        check_all();
    endtask

    task automatic hold(input logic [6:0] s, input int n, input logic r);
        repeat (n) cycle(s, r);
    endtask

    // Assert reset between edges and confirm it acts before any clock
    task automatic do_reset();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check("rst_async_valid", dv, 1'b0);
        check("rst_async_count", cnt, 3'd0);
        check_all();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int first;
        int kind;
        int len;
        logic [6:0] p;

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_all();

        // Blank bus out of reset never commits
        hold(7'h00, 20, 1'b0);

        // Clean glyph latency
        first = -1;
        for (int i = 1; i <= 12; i++) begin
            cycle(7'h06, 1'b0);
            if (dv && first < 0) first = i;
        end
        check("latency_1", first, 6);
        check("digit_1", dout, 4'h1);
        hold(7'h00, 3, 1'b1);

        // Bounce then settle
        repeat (4) begin
            hold(7'h5B, 2, 1'b0);
            hold(7'h00, 2, 1'b0);
        end
        hold(7'h5B, 10, 1'b0);
        check("bounce_digit", dout, 4'h2);
        check("bounce_blank", blk, 1'b0);
        hold(7'h5B, 2, 1'b1);

        // Invalid glyph then blank
        hold(7'h01, 8, 1'b1);
        hold(7'h00, 8, 1'b1);

        // Fill to overflow, then drain
        for (int i = 0; i < 5; i++) hold(GLYPH[i], 8, 1'b0);
        check("fill_overflow", ovf, 1'b1);
        hold(7'h00, 6, 1'b1);
        check("drain_overflow", ovf, 1'b1);

        // Mid-operation reset with a pattern mid-window
        do_reset();
        hold(7'h3F, 8, 1'b0);
        hold(7'h06, 8, 1'b0);
        hold(7'h6D, 3, 1'b0);
        do_reset();
        first = -1;
        for (int i = 1; i <= 10; i++) begin
            cycle(7'h6D, 1'b0);
            if (dv && first < 0) first = i;
        end
        check("latency_5", first, S + 2);
        check("digit_5", dout, 4'h5);

        // Random phases of glyphs, blanks, junk and bounce
        for (int ph = 0; ph < 300; ph++) begin
            kind = $urandom_range(0, 19);
            len  = $urandom_range(1, 10);
            if (kind == 19) begin
                do_reset();
            end else if (kind < 12) begin
                p = GLYPH[$urandom_range(0, 15)];
                repeat (len) cycle(p, $urandom_range(0, 3) == 0);
            end else if (kind < 14) begin
                repeat (len) cycle(7'h00, $urandom_range(0, 3) == 0);
            end else if (kind < 16) begin
                do p = 7'($urandom_range(1, 127)); while (decode(p) >= 0);
                repeat (len) cycle(p, $urandom_range(0, 3) == 0);
            end else begin
                p = GLYPH[$urandom_range(0, 15)];
                repeat (len) begin
                    hold(p, 2, $urandom_range(0, 1) == 0);
                    hold(7'h00, 2, $urandom_range(0, 1) == 0);
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
